multicycle_data_path: RTL and testbench

MULTICYCLE_DATA_PATH -- requirements
Module: multicycle_data_path

---
 rtl/multicycle_data_path.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_data_path.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_data_path.sv
// rtl/multicycle_data_path.sv - multicycle FETCH/DECODE/EXECUTE/MEM/WB CPU datapath
// Optional instruction counter port instr_count enabled by macro MCDP_PERF_CNT_EN.
module multicycle_data_path #(
  parameter int WIDTH    = 24,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       state,
  output logic [3:0]       flags
`ifdef MCDP_PERF_CNT_EN
  ,
  output logic [31:0]      instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  state_t           state_q, state_n;
  logic [23:0]      ir;
  logic [WIDTH-1:0] a_q, b_q, wd_q, alu_out, mdr;
  logic [WIDTH-1:0] regs [16];
  logic             cond_ok_q;

  logic [2:0]       cond;
  logic [1:0]       op;
  logic [3:0]       funct, rd, rn, rm;
  logic [WIDTH-1:0] imm, br_off, addr_sum, pc_inc;
  logic [WIDTH-1:0] alu_b, alu_y;
  logic             alu_c, alu_v, cond_pass;

  assign cond  = ir[23:21];
  assign op    = ir[20:19];
  assign funct = ir[18:15];
  assign rd    = ir[14:11];
  assign rn    = ir[10:7];
  assign rm    = ir[6:3];

  assign imm      = {{(WIDTH-7){1'b0}}, ir[6:0]};
  assign br_off   = {{(WIDTH-19){ir[18]}}, ir[18:0]} << 2;
  assign addr_sum = a_q + imm;
  assign pc_inc   = pc + STEP;

  assign state     = state_q;
  assign mem_wdata = wd_q;

  // flags bit order is N,Z,C,V from msb down
  always_comb begin
    case (cond)
      3'b000:  cond_pass = 1'b1;
      3'b001:  cond_pass = flags[2];
      3'b010:  cond_pass = !flags[2];
      3'b011:  cond_pass = flags[3] ^ flags[0];
      3'b100:  cond_pass = !(flags[3] ^ flags[0]);
      default: cond_pass = 1'b0;
    endcase
  end

  // C on subtract is the borrow out, so equal operands leave C clear
  always_comb begin
    alu_b = funct[3] ? imm : b_q;
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (funct[2:1])
      2'b00: begin
        {alu_c, alu_y} = {1'b0, a_q} + {1'b0, alu_b};
        alu_v = (a_q[WIDTH-1] == alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b01: begin
        {alu_c, alu_y} = {1'b0, a_q} - {1'b0, alu_b};
        alu_v = (a_q[WIDTH-1] != alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b10:   alu_y = a_q & alu_b;
      default: alu_y = a_q | alu_b;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXECUTE;
      S_EXECUTE: begin
        case (op)
          2'b00:   state_n = S_WB;
          2'b01:   state_n = cond_pass ? S_MEM : S_FETCH;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = funct[0];
        mem_addr = alu_out;
        if (mem_ack) state_n = funct[0] ? S_FETCH : S_WB;
      end
      S_WB:    state_n = S_FETCH;
      default: state_n = S_FETCH;
    endcase
    // state sits at FETCH during reset; the request must not leak out
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc        <= WIDTH'(RESET_PC);
      flags     <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wd_q      <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      cond_ok_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        S_FETCH: if (mem_ack) ir <= mem_rdata[23:0];
        S_DECODE: begin
          a_q  <= regs[rn];
          b_q  <= regs[rm];
          wd_q <= regs[rd];
        end
        S_EXECUTE: begin
          cond_ok_q <= cond_pass;
          case (op)
            2'b00: begin
              alu_out <= alu_y;
              if (funct[0] && cond_pass)
                flags <= {alu_y[WIDTH-1], (alu_y == '0), alu_c, alu_v};
            end
            2'b01: begin
              alu_out <= addr_sum;
              if (!cond_pass) pc <= pc_inc;
            end
            2'b10:   pc <= cond_pass ? pc_inc + br_off : pc_inc;
            default: pc <= pc_inc;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (funct[0]) pc <= pc_inc;
            else          mdr <= mem_rdata;
          end
        end
        S_WB: begin
          if (cond_ok_q) regs[rd] <= (op == 2'b01) ? mdr : alu_out;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef MCDP_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_count <= '0;
    else if ((state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) && state_n == S_FETCH)
      instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_data_path.sv
// tb/tb_multicycle_data_path.sv - directed bench for multicycle_data_path with store scoreboard
// Uses WIDTH=32 and checks instr_count when MCDP_PERF_CNT_EN is defined.
module tb_multicycle_data_path;

`ifdef MCDP_PERF_CNT_EN
  localparam int TW = 32;
`else
  localparam int TW = 24;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ack;
  logic [TW-1:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]    state;
  logic [3:0]    flags;
`ifdef MCDP_PERF_CNT_EN
  logic [31:0]   instr_count;
`endif

  logic [TW-1:0] mem [256];
  int            ack_delay = 0;
  int            wait_cnt = 0;
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] exp_addr[$];
  logic [TW-1:0] exp_data[$];

  multicycle_data_path #(.WIDTH(TW), .PC_STEP(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .state(state), .flags(flags)
`ifdef MCDP_PERF_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  initial forever #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completed stores are compared against the scoreboard and written to memory
  always @(negedge clk) begin
    if (!rst && mem_req && mem_we && mem_ack) begin
      if (exp_addr.size() == 0) begin
        chk("store_unexpected", mem_addr, 0);
      end else begin
        chk("store_addr", mem_addr, exp_addr.pop_front());
        chk("store_data", mem_wdata, exp_data.pop_front());
      end
      mem[mem_addr[9:2]] = mem_wdata;
    end
  end

  function automatic logic [TW-1:0] enc(input logic [2:0] c, input logic [1:0] o, input logic [3:0] f,
                                        input logic [3:0] d, input logic [3:0] n, input logic [6:0] lo);
    return TW'({c, o, f, d, n, lo});
  endfunction

  function automatic logic [TW-1:0] br(input logic [2:0] c, input logic [18:0] off);
    return TW'({c, 2'b10, off});
  endfunction

  task automatic push(input logic [TW-1:0] a, input logic [TW-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic run_to(input logic [31:0] target, input int exp_cyc, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pc == TW'(target) && state == 3'd0) && n < 100);
    chk({tag, "_pc"}, pc, target);
    chk({tag, "_cycles"}, n, exp_cyc);
  endtask

  initial begin
    logic [TW-1:0] neg5;
    logic [TW-1:0] nop;
    int n;
    neg5 = '0 - TW'(5);
    nop  = TW'({3'b000, 2'b11, 19'd0});
    for (int i = 0; i < 256; i++) mem[i] = '0;

    mem[0]  = enc(3'd0, 2'b00, 4'b1000, 4'd1, 4'd0, 7'd5);
    mem[1]  = enc(3'd0, 2'b00, 4'b1000, 4'd2, 4'd0, 7'd3);
    mem[2]  = enc(3'd0, 2'b00, 4'b1000, 4'd3, 4'd0, 7'd3);
    mem[3]  = enc(3'd0, 2'b00, 4'b0011, 4'd7, 4'd2, {4'd3, 3'd0});
    mem[4]  = br(3'b001, 19'd2);
    mem[5]  = enc(3'd0, 2'b00, 4'b1000, 4'd1, 4'd0, 7'd99);
    mem[6]  = enc(3'd0, 2'b00, 4'b1000, 4'd1, 4'd0, 7'd99);
    mem[7]  = enc(3'd0, 2'b00, 4'b1000, 4'd5, 4'd0, 7'd64);
    mem[8]  = enc(3'd0, 2'b00, 4'b0000, 4'd5, 4'd5, {4'd5, 3'd0});
    mem[9]  = enc(3'd0, 2'b00, 4'b0000, 4'd5, 4'd5, {4'd5, 3'd0});
    mem[10] = enc(3'd0, 2'b01, 4'b0000, 4'd4, 4'd0, 7'd124);
    mem[11] = enc(3'd0, 2'b01, 4'b0001, 4'd4, 4'd5, 7'h10);
    mem[12] = enc(3'd0, 2'b01, 4'b0000, 4'd6, 4'd5, 7'h10);
    mem[13] = enc(3'd0, 2'b01, 4'b0001, 4'd6, 4'd5, 7'h20);
    mem[14] = enc(3'd0, 2'b01, 4'b0001, 4'd1, 4'd5, 7'h24);
    mem[15] = enc(3'd0, 2'b00, 4'b0011, 4'd9, 4'd0, {4'd1, 3'd0});
    mem[16] = enc(3'd0, 2'b00, 4'b0111, 4'd10, 4'd1, {4'd2, 3'd0});
    mem[17] = enc(3'b001, 2'b00, 4'b1000, 4'd1, 4'd0, 7'd77);
    mem[18] = enc(3'd0, 2'b01, 4'b0001, 4'd1, 4'd5, 7'h28);
    mem[19] = nop;
    mem[20] = br(3'b001, 19'd5);
    mem[21] = br(3'b010, 19'd1);
    mem[22] = br(3'b000, 19'd1);
    mem[23] = br(3'b010, 19'h7FFFE);
    mem[24] = enc(3'd0, 2'b01, 4'b0001, 4'd9, 4'd5, 7'h2C);
    mem[25] = enc(3'd0, 2'b01, 4'b0001, 4'd10, 4'd5, 7'h30);
    mem[26] = enc(3'd0, 2'b01, 4'b0001, 4'd10, 4'd5, 7'h34);
    mem[31] = TW'(24'hABCDEF);

    push(TW'(32'h110), TW'(24'hABCDEF));
    push(TW'(32'h120), TW'(24'hABCDEF));
    push(TW'(32'h124), TW'(5));
    push(TW'(32'h128), TW'(5));
    push(TW'(32'h12C), neg5);
    push(TW'(32'h130), TW'(7));

    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_state", state, 0);
    chk("rst_flags", flags, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);

    rst = 1'b0;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    run_to(4, 4, "addi_r1");

    ack_delay = 3;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, 4);
      chk("wait_state", state, 0);
      @(negedge clk);
    end
    chk("wait_decode", state, 1);
    ack_delay = 0;
    run_to(8, 3, "addi_r2");
    run_to(12, 4, "addi_r3");
    run_to(16, 4, "subs");
    chk("subs_flags", flags, 4'b0100);
    run_to(28, 3, "beq_taken");
    run_to(40, 12, "build_r5");
    run_to(44, 5, "load_r4");
    run_to(48, 4, "store_r4");
    run_to(52, 5, "load_r6");
    run_to(60, 8, "store_r6_r1");
    run_to(64, 4, "subs_neg");
    chk("neg_flags", flags, 4'b1010);
    run_to(68, 4, "orrs");
    chk("orr_flags", flags, 4'b0000);
    run_to(72, 4, "cond_fail_dp");
    chk("cond_fail_flags", flags, 4'b0000);
    run_to(76, 4, "store_r1");
    run_to(80, 3, "nop");
    run_to(84, 3, "beq_not_taken");
    run_to(92, 3, "bne_fwd");
    run_to(88, 3, "bne_back");
    run_to(96, 3, "bal");
    run_to(104, 8, "store_r9_r10");

    ack_delay = 20;
    n = 0;
    while (state != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("victim_state", state, 3);
    @(negedge clk);
    chk("victim_req", mem_req, 1);
    chk("victim_we", mem_we, 1);
    chk("victim_addr", mem_addr, 32'h134);
    #2 rst = 1'b1;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_pc", pc, 0);
    chk("abort_state", state, 0);
    chk("scoreboard_empty", exp_addr.size(), 0);

    ack_delay = 0;
    for (int i = 0; i < 12; i++) mem[i] = nop;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("nops_pc", pc, 40);
    chk("nops_state", state, 0);
    chk("nops_flags", flags, 0);
`ifdef MCDP_PERF_CNT_EN
    chk("instr_count", instr_count, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
